// File: rtl/tick_gen.sv
// Multi-channel programmable clock-enable generator: per-channel strobe every d clocks
// plus a mode-selected output (the strobe, or a square wave of period 2d).
module tick_gen #(
  parameter int NCH = 4,
  parameter int DIV_W = 16,
  parameter int DEF_DIV = 4,
  parameter logic [NCH-1:0] RST_EN = {NCH{1'b1}},
  parameter logic [NCH-1:0] RST_MODE = {NCH{1'b0}},
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cfg_mode,
  input  logic             cfg_en,
  input  logic             sync,
  output logic [NCH-1:0]   stb,
  output logic [NCH-1:0]   out
);

  logic [DIV_W-1:0] div_q [NCH];
  logic [DIV_W-1:0] cnt_q [NCH];
  logic [DIV_W-1:0] last  [NCH];
  logic [NCH-1:0]   mode_q, en_q, stb_q, sq_q, wr_hit;

  // Terminal count is d-1; a zero divisor behaves as d = 1, so it also terminates at 0.
  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < NCH; i++) begin
      last[i]   = (div_q[i] == '0) ? '0 : div_q[i] - 1'b1;
      wr_hit[i] = cfg_we && (cfg_ch == CH_W'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        div_q[i] <= DIV_W'(DEF_DIV);
        cnt_q[i] <= '0;
      end
      mode_q <= RST_MODE;
      en_q   <= RST_EN;
      stb_q  <= '0;
      sq_q   <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (wr_hit[i]) begin
          div_q[i]  <= cfg_div;
          mode_q[i] <= cfg_mode;
          en_q[i]   <= cfg_en;
          cnt_q[i]  <= '0;
          stb_q[i]  <= 1'b0;
          sq_q[i]   <= 1'b0;
        end else if (!en_q[i] || sync) begin
          cnt_q[i] <= '0;
          stb_q[i] <= 1'b0;
          sq_q[i]  <= 1'b0;
        end else if (cnt_q[i] == last[i]) begin
          cnt_q[i] <= '0;
          stb_q[i] <= 1'b1;
          sq_q[i]  <= ~sq_q[i];
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
          stb_q[i] <= 1'b0;
        end
      end
    end
  end

  assign stb = stb_q;
  assign out = (mode_q & sq_q) | (~mode_q & stb_q);

endmodule
